// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of a UART transmitter. Bytes are launched
// one at a time with a TX_DV pulse, and the next launch waits for TX_Done.
module uart_tx_feeder #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        flush,
  input  logic        clr_ovf,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        overflow,
  output logic        TX_DV,
  output logic [7:0]  TX_BYTE,
  input  logic        TX_Active,
  input  logic        TX_Done
);

  // state  | meaning
  // IDLE   | waiting for queued data and an idle transmitter
  // LAUNCH | TX_DV high for one cycle, FIFO head popped
  // BUSY   | byte handed over, waiting for TX_Done
  // GAP    | one spacer cycle before the next launch
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  state_t        state, state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_write, do_pop, drop, start;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign TX_DV    = (state == LAUNCH);
  // full is the pre-edge level, so a same-cycle pop never rescues a write
  assign do_write = wr_en && !full && !flush;
  assign drop     = wr_en && full && !flush;
  assign do_pop   = (state == LAUNCH) && !flush;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !TX_Active && !flush) begin
          state_next = LAUNCH;
          start      = 1'b1;
        end
      end
      LAUNCH:  state_next = BUSY;
      BUSY:    if (TX_Done) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      TX_BYTE <= 8'h00;
    end else begin
      state <= state_next;
      if (start) TX_BYTE <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !do_pop)      count <= count + 1'b1;
      else if (!do_write && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule
